// File: rtl/egress_scheduler.sv
// Packet-locked round-robin scheduler: shares one AXI-Stream egress among NUM_REQ
// requesters, one whole frame per grant, with a stall watchdog that aborts dead frames.
package egress_scheduler_pkg;
  typedef struct packed {
    logic        tvalid;
    logic [15:0] tdata;
    logic [1:0]  tdest;
    logic        tlast;
  } axis_d_source_t;

  typedef struct packed {
    logic tready;
  } axis_d_sink_t;
endpackage

module egress_scheduler
  import egress_scheduler_pkg::*;
#(
  parameter int NUM_REQ     = 4,
  parameter int STALL_LIMIT = 15,
  parameter int CTR_WIDTH   = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 en,
  input  axis_d_source_t       req_source [NUM_REQ],
  output axis_d_sink_t         req_sink   [NUM_REQ],
  output axis_d_source_t       egress_source,
  input  axis_d_sink_t         egress_sink,
  output logic [NUM_REQ-1:0]   grant,
  output logic                 abort,
  output logic [CTR_WIDTH-1:0] frame_count,
  output logic [CTR_WIDTH-1:0] abort_count
);

  localparam int IDX_W   = $clog2(NUM_REQ);
  localparam int STALL_W = $clog2(STALL_LIMIT + 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_BUSY,
    ST_ABORT,
    ST_DRAIN
  } state_t;

  state_t             state;
  logic [IDX_W-1:0]   gidx;
  logic [IDX_W-1:0]   last_idx;
  logic [STALL_W-1:0] stall_cnt;
  logic [1:0]         tdest_lat;

  logic [NUM_REQ-1:0] valid_vec;
  logic [IDX_W-1:0]   win_idx;
  axis_d_source_t     g_src;
  logic               tlast_acc;
  logic               stall_hit;
  logic               drain_done;

  // First valid requester after the previous grantee, wrapping modulo NUM_REQ.
  function automatic logic [IDX_W-1:0] rr_pick(input logic [NUM_REQ-1:0] vld,
                                              input logic [IDX_W-1:0]   last);
    logic [IDX_W-1:0] pick;
    logic [IDX_W-1:0] cand;
    logic             found;
    pick  = '0;
    found = 1'b0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand = IDX_W'((int'(last) + k) % NUM_REQ);
      if (!found && vld[cand]) begin
        pick  = cand;
        found = 1'b1;
      end
    end
    return pick;
  endfunction

  function automatic logic [NUM_REQ-1:0] onehot(input logic [IDX_W-1:0] idx);
    logic [NUM_REQ-1:0] oh;
    oh      = '0;
    oh[idx] = 1'b1;
    return oh;
  endfunction

  // Statistics counters wrap silently at 2^CTR_WIDTH.
  function automatic logic [CTR_WIDTH-1:0] ctr_inc(input logic [CTR_WIDTH-1:0] c);
    return c + 1'b1;
  endfunction

  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) valid_vec[i] = req_source[i].tvalid;
  end

  assign win_idx    = rr_pick(valid_vec, last_idx);
  assign g_src      = req_source[gidx];
  assign tlast_acc  = g_src.tvalid && egress_sink.tready && g_src.tlast;
  // Abort fires on the edge that closes the STALL_LIMIT-th consecutive idle cycle.
  assign stall_hit  = !g_src.tvalid && (stall_cnt == STALL_W'(STALL_LIMIT - 1));
  assign drain_done = g_src.tvalid && g_src.tlast;

  // Zero-latency egress mux and per-requester ready steering.
  always_comb begin
    egress_source = '0;
    for (int i = 0; i < NUM_REQ; i++) req_sink[i].tready = 1'b0;
    case (state)
      ST_BUSY: begin
        egress_source              = g_src;
        req_sink[gidx].tready      = egress_sink.tready;
      end
      ST_ABORT: begin
        egress_source.tvalid = 1'b1;
        egress_source.tdest  = tdest_lat;
        egress_source.tlast  = 1'b1;
      end
      ST_DRAIN: begin
        req_sink[gidx].tready = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= ST_IDLE;
      gidx        <= '0;
      last_idx    <= IDX_W'(NUM_REQ - 1);
      stall_cnt   <= '0;
      tdest_lat   <= '0;
      grant       <= '0;
      abort       <= 1'b0;
      frame_count <= '0;
      abort_count <= '0;
    end else begin
      abort <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (en && (|valid_vec)) begin
            gidx      <= win_idx;
            last_idx  <= win_idx;
            grant     <= onehot(win_idx);
            tdest_lat <= req_source[win_idx].tdest;
            stall_cnt <= '0;
            state     <= ST_BUSY;
          end
        end
        ST_BUSY: begin
          if (tlast_acc) begin
            frame_count <= ctr_inc(frame_count);
            grant       <= '0;
            state       <= ST_IDLE;
          end else if (g_src.tvalid) begin
            stall_cnt <= '0;
          end else begin
            stall_cnt <= stall_cnt + 1'b1;
            if (stall_hit) state <= ST_ABORT;
          end
        end
        ST_ABORT: begin
          if (egress_sink.tready) begin
            abort       <= 1'b1;
            abort_count <= ctr_inc(abort_count);
            stall_cnt   <= '0;
            state       <= ST_DRAIN;
          end
        end
        ST_DRAIN: begin
          if (drain_done) begin
            grant <= '0;
            state <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
